hazard_ctrl: RTL and testbench

- Control-side counterpart of the IF/ID pipeline register. Generates the stall (HD) and flush signals that the IF/ID register consumes, plus the PC write-enable and the ID/EX bubble.
- Resolves three conditions:
  - load-use data hazards;
  - taken branch/jump redirects;
  - multi-cycle data-memory waits, handled by a small FSM with a timeout watchdog.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the IF/ID register: load-use, branch redirect and
// data-memory wait handling, with a timeout watchdog and saturating perf counters.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int WAIT_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs_i,
    input  logic [4:0]       ID_rt_i,
    input  logic             ID_useRt_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             clr_cnt_i,
    output logic             PC_Write_o,
    output logic             HD_o,
    output logic             Flush_o,
    output logic             bubble_o,
    output logic             freeze_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              mw;
    logic              lu;

    assign mw = mem_req_i & ~mem_ack_i;
    assign lu = EX_MemRead_i & (EX_rt_i != 5'd0) &
                ((EX_rt_i == ID_rs_i) | (ID_useRt_i & (EX_rt_i == ID_rt_i)));
    assign wait_inc = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;

    // Memory wait outranks load-use, which outranks a redirect; a redirect
    // hidden by a stall re-presents from the held ID stage afterwards.
    always_comb begin
        PC_Write_o = 1'b1;
        HD_o       = 1'b0;
        Flush_o    = 1'b0;
        bubble_o   = 1'b0;
        freeze_o   = 1'b0;
        if (mw) begin
            PC_Write_o = 1'b0;
            HD_o       = 1'b1;
            freeze_o   = 1'b1;
        end else if (lu) begin
            PC_Write_o = 1'b0;
            HD_o       = 1'b1;
            bubble_o   = 1'b1;
        end else if (branch_taken_i) begin
            Flush_o    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= {{(WAIT_W-1){1'b0}}, 1'b1};
                        if (TIMEOUT_V == {{(WAIT_W-1){1'b0}}, 1'b1}) begin
                            err_o <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mw) begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == TIMEOUT_V) begin
                            err_o <= 1'b1;
                        end
                    end else begin
                        // Ack or a withdrawn request both release the pipeline.
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (HD_o && stall_cnt_o != CNT_MAX) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (Flush_o && flush_cnt_o != CNT_MAX) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a behavioural model queues expected values as
// each step is driven; they are popped and compared when the DUT responds.
module tb_hazard_ctrl;

    localparam int WAIT_W  = 3;
    localparam int TIMEOUT = 4;
    localparam int BIG_MAX = 65535;
    localparam int SAT_MAX = 3;
    localparam int WAIT_MAX = 7;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  ID_rs_i = '0;
    logic [4:0]  ID_rt_i = '0;
    logic        ID_useRt_i = 1'b0;
    logic        EX_MemRead_i = 1'b0;
    logic [4:0]  EX_rt_i = '0;
    logic        branch_taken_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic        clr_cnt_i = 1'b0;

    logic        pc_write, hd, flush, bubble, freeze, err;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_hd, s_flush, s_bubble, s_freeze, s_err;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    hazard_ctrl #(.CNT_W(16), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i), .ID_useRt_i(ID_useRt_i),
        .EX_MemRead_i(EX_MemRead_i), .EX_rt_i(EX_rt_i),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i),
        .mem_ack_i(mem_ack_i), .clr_cnt_i(clr_cnt_i),
        .PC_Write_o(pc_write), .HD_o(hd), .Flush_o(flush),
        .bubble_o(bubble), .freeze_o(freeze), .err_o(err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i), .ID_useRt_i(ID_useRt_i),
        .EX_MemRead_i(EX_MemRead_i), .EX_rt_i(EX_rt_i),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i),
        .mem_ack_i(mem_ack_i), .clr_cnt_i(clr_cnt_i),
        .PC_Write_o(s_pc_write), .HD_o(s_hd), .Flush_o(s_flush),
        .bubble_o(s_bubble), .freeze_o(s_freeze), .err_o(s_err),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string tag;
        logic  pc, hd, fl, bub, frz, err;
        int    stall, flush, stall_s, flush_s;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    bit m_wait_state = 1'b0;
    int m_wcnt = 0;
    bit m_err = 1'b0;
    int m_stall = 0, m_flush = 0, m_stall_s = 0, m_flush_s = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_wait_state = 1'b0;
        m_wcnt = 0;
        m_err = 1'b0;
        m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    endtask

    // Drive one cycle of inputs and queue what the controller must produce.
    task automatic apply_stimulus(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic use_rt, input logic mem_read, input logic [4:0] ex_rt,
                                  input logic br, input logic req, input logic ack, input logic clr);
        exp_t e;
        logic mw, lu;
        ID_rs_i = rs; ID_rt_i = rt; ID_useRt_i = use_rt;
        EX_MemRead_i = mem_read; EX_rt_i = ex_rt; branch_taken_i = br;
        mem_req_i = req; mem_ack_i = ack; clr_cnt_i = clr;

        mw = req && !ack;
        lu = mem_read && (ex_rt != 0) && ((ex_rt == rs) || (use_rt && ex_rt == rt));
        e.tag = tag;
        e.pc = 1'b1; e.hd = 1'b0; e.fl = 1'b0; e.bub = 1'b0; e.frz = 1'b0;
        if (mw) begin
            e.pc = 1'b0; e.hd = 1'b1; e.frz = 1'b1;
        end else if (lu) begin
            e.pc = 1'b0; e.hd = 1'b1; e.bub = 1'b1;
        end else if (br) begin
            e.fl = 1'b1;
        end

        if (clr) begin
            m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
        end else begin
            if (e.hd) begin
                m_stall   = (m_stall   < BIG_MAX) ? m_stall + 1 : m_stall;
                m_stall_s = (m_stall_s < SAT_MAX) ? m_stall_s + 1 : m_stall_s;
            end
            if (e.fl) begin
                m_flush   = (m_flush   < BIG_MAX) ? m_flush + 1 : m_flush;
                m_flush_s = (m_flush_s < SAT_MAX) ? m_flush_s + 1 : m_flush_s;
            end
        end

        if (mw) begin
            m_wcnt = m_wait_state ? ((m_wcnt < WAIT_MAX) ? m_wcnt + 1 : m_wcnt) : 1;
            m_wait_state = 1'b1;
            if (m_wcnt == TIMEOUT) m_err = 1'b1;
        end else begin
            m_wait_state = 1'b0;
            m_wcnt = 0;
        end

        e.err = m_err;
        e.stall = m_stall; e.flush = m_flush;
        e.stall_s = m_stall_s; e.flush_s = m_flush_s;
        sb_q.push_back(e);
    endtask

    // Compare combinational controls mid-cycle, then registered state after the edge.
    task automatic check_output();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        #1;
        chk({e.tag, ".pc_write"}, 32'(pc_write), 32'(e.pc));
        chk({e.tag, ".hd"},       32'(hd),       32'(e.hd));
        chk({e.tag, ".flush"},    32'(flush),    32'(e.fl));
        chk({e.tag, ".bubble"},   32'(bubble),   32'(e.bub));
        chk({e.tag, ".freeze"},   32'(freeze),   32'(e.frz));
        chk({e.tag, ".sat_hd"},   32'(s_hd),     32'(e.hd));
        @(posedge clk_i);
        #1;
        chk({e.tag, ".err"},       32'(err),         32'(e.err));
        chk({e.tag, ".stall_cnt"}, 32'(stall_cnt),   32'(e.stall));
        chk({e.tag, ".flush_cnt"}, 32'(flush_cnt),   32'(e.flush));
        chk({e.tag, ".sat_stall"}, 32'(s_stall_cnt), 32'(e.stall_s));
        chk({e.tag, ".sat_flush"}, 32'(s_flush_cnt), 32'(e.flush_s));
        @(negedge clk_i);
    endtask

    task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rt, input logic mem_read, input logic [4:0] ex_rt,
                        input logic br, input logic req, input logic ack, input logic clr);
        apply_stimulus(tag, rs, rt, use_rt, mem_read, ex_rt, br, req, ack, clr);
        check_output();
    endtask

    initial begin
        #1;
        chk("rst.pc_write", 32'(pc_write), 32'd1);
        chk("rst.hd", 32'(hd), 32'd0);
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.bubble", 32'(bubble), 32'd0);
        chk("rst.freeze", 32'(freeze), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst.flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();

        //    tag            rs  rt  useRt rd  exRt br  req ack clr
        step("idle",         0,  0,  0,    0,  0,   0,  0,  0,  0);
        step("lu_rs",        5,  0,  0,    1,  5,   0,  0,  0,  0);
        step("lu_rt_zero",   0,  0,  0,    1,  0,   0,  0,  0,  0);
        step("lu_rt",        3,  7,  1,    1,  7,   0,  0,  0,  0);
        step("rt_unused",    3,  7,  0,    1,  7,   0,  0,  0,  0);
        step("branch",       0,  0,  0,    0,  0,   1,  0,  0,  0);
        step("branch_lu",    5,  0,  0,    1,  5,   1,  0,  0,  0);
        step("branch_after", 5,  0,  0,    0,  0,   1,  0,  0,  0);

        for (int i = 0; i < 3; i++)
            step($sformatf("mem_wait%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("mem_release_br", 0, 0, 0, 0, 0, 1, 1, 1, 0);
        step("req_ack_same",   0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("req_drop0",      0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("req_drop1",      0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("req_gone",       0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++)
            step($sformatf("timeout%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("timeout_ack",  0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("timeout_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset pulse between edges while the FSM is waiting on memory.
        step("pre_reset_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        rst_i = 1'b0;
        #1;
        chk("async_rst.err", 32'(err), 32'd0);
        chk("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async_rst.flush_cnt", 32'(flush_cnt), 32'd0);
        chk("async_rst.freeze", 32'(freeze), 32'd1);
        mem_req_i = 1'b0;
        #1;
        rst_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        step("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++)
            step($sformatf("sat_lu%0d", i), 9, 0, 0, 1, 9, 0, 0, 0, 0);
        step("clr_with_stall", 9, 0, 0, 1, 9, 0, 0, 0, 1);
        step("flush_then_clr", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("clr_with_flush", 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step("final_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
